// File: rtl/snn_pkg.sv
// snn_pkg: shared SNN defaults and the AER event record used by downstream consumers.
// Rev 1.0
`default_nettype none

package snn_pkg;
  localparam int c_NUM_NEURONS = 8;
  localparam int c_TS_W        = 16;
  localparam int c_DROP_W      = 16;
  localparam int c_ADDR_W      = $clog2(c_NUM_NEURONS);

  typedef struct packed {
    logic [c_ADDR_W-1:0] addr;
    logic [c_TS_W-1:0]   tstamp;
  } aer_event_t;
endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search starting one past i_ptr.
// Rev 1.0
`default_nettype none

module rr_priority_pick #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
  input  logic [NUM_NEURONS-1:0] i_req,
  input  logic [ADDR_W-1:0]      i_ptr,
  output logic [ADDR_W-1:0]      o_grant,
  output logic                   o_any
);

  int w_idx;

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_NEURONS; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_NEURONS;
      if (!o_any && i_req[w_idx]) begin
        o_any   = 1'b1;
        o_grant = ADDR_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter: per-neuron pending bits, round-robin AER output slot, saturating drop counter.
// Optional macro SPIKE_TIMESTAMP_EN adds a free-running timestamp on aer_tstamp. Rev 1.0
`default_nettype none

module spike_aer_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = c_NUM_NEURONS,
  parameter int ADDR_W      = $clog2(NUM_NEURONS),
  parameter int DROP_W      = c_DROP_W
`ifdef SPIKE_TIMESTAMP_EN
  ,
  parameter int TS_W        = c_TS_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   aer_valid,
  input  logic                   aer_ready,
  output logic [ADDR_W-1:0]      aer_addr,
  output logic [DROP_W-1:0]      drop_count
`ifdef SPIKE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]        aer_tstamp
`endif
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = DROP_W + CNT_W;

  logic [NUM_NEURONS-1:0] r_pending;
  logic                   r_valid;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      r_ptr;
  logic [DROP_W-1:0]      r_drop;

  logic                   w_free;
  logic                   w_any;
  logic                   w_load;
  logic [ADDR_W-1:0]      w_win;
  logic [NUM_NEURONS-1:0] w_grant_vec;
  logic [NUM_NEURONS-1:0] w_drop_vec;
  logic [CNT_W-1:0]       w_drop_cnt;
  logic [SUM_W-1:0]       w_sum;
  logic [DROP_W-1:0]      w_drop_next;

  rr_priority_pick #(
    .NUM_NEURONS (NUM_NEURONS),
    .ADDR_W      (ADDR_W)
  ) u_pick (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_grant (w_win),
    .o_any   (w_any)
  );

  assign w_free      = !r_valid || aer_ready;
  assign w_load      = w_free && w_any;
  assign w_grant_vec = w_load ? (NUM_NEURONS'(1) << w_win) : '0;
  // A spike landing on the bit being granted re-arms it instead of colliding.
  assign w_drop_vec  = spike_in & r_pending & ~w_grant_vec;

  always_comb begin
    w_drop_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_drop_cnt = w_drop_cnt + CNT_W'(w_drop_vec[i]);
    end
  end

  assign w_sum       = SUM_W'(r_drop) + SUM_W'(w_drop_cnt);
  assign w_drop_next = (|w_sum[SUM_W-1:DROP_W]) ? '1 : w_sum[DROP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_ptr     <= ADDR_W'(NUM_NEURONS - 1);
      r_drop    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_vec) | spike_in;
      r_drop    <= w_drop_next;
      if (w_load) begin
        r_valid <= 1'b1;
        r_addr  <= w_win;
        r_ptr   <= w_win;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign aer_valid  = r_valid;
  assign aer_addr   = r_addr;
  assign drop_count = r_drop;

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_tstamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts     <= '0;
      r_tstamp <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_load) begin
        r_tstamp <= r_ts;
      end
    end
  end

  assign aer_tstamp = r_tstamp;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_aer_arbiter.sv
// tb_spike_aer_arbiter: directed and random stimulus checked each cycle against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_spike_aer_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] spike_in;
  logic         aer_valid;
  logic         aer_ready;
  logic [2:0]   aer_addr;
  logic [15:0]  drop_count;
`ifdef SPIKE_TIMESTAMP_EN
  logic [15:0]  aer_tstamp;
`endif

  spike_aer_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_addr   (aer_addr),
    .drop_count (drop_count)
`ifdef SPIKE_TIMESTAMP_EN
    ,
    .aer_tstamp (aer_tstamp)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: pending flags, the presented event and counters as plain ints.
  int m_pend [N];
  int m_valid, m_addr, m_last, m_drop, m_ts, m_tst;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_addr = 0; m_last = N - 1; m_drop = 0; m_ts = 0; m_tst = 0;
  endtask

  task automatic model_step(input logic [N-1:0] spk, input logic rdy);
    int win, drops, sum;
    bit free, grant;
    free  = (m_valid == 0) || rdy;
    win   = -1;
    for (int k = 1; k <= N; k++) begin
      if (win < 0 && m_pend[(m_last + k) % N] != 0) win = (m_last + k) % N;
    end
    grant = free && (win >= 0);
    drops = 0;
    for (int i = 0; i < N; i++) begin
      bit granted_here;
      granted_here = grant && (i == win);
      if (spk[i] && m_pend[i] != 0 && !granted_here) drops++;
      m_pend[i] = ((m_pend[i] != 0 && !granted_here) || spk[i]) ? 1 : 0;
    end
    if (grant) begin
      m_valid = 1; m_addr = win; m_last = win; m_tst = m_ts;
    end else if (free) begin
      m_valid = 0;
    end
    sum    = m_drop + drops;
    m_drop = (sum > 65535) ? 65535 : sum;
    m_ts   = (m_ts + 1) % 65536;
  endtask

  task automatic model_check();
    cmp("valid", 32'(aer_valid), 32'(m_valid));
    if (m_valid != 0) cmp("addr", 32'(aer_addr), 32'(m_addr));
    cmp("drop_count", 32'(drop_count), 32'(m_drop));
`ifdef SPIKE_TIMESTAMP_EN
    if (m_valid != 0) cmp("tstamp", 32'(aer_tstamp), 32'(m_tst));
`endif
  endtask

  // Called at a negedge; applies inputs for one cycle and checks the state after the edge.
  task automatic tick(input logic [N-1:0] spk, input logic rdy);
    spike_in  = spk;
    aer_ready = rdy;
    model_step(spk, rdy);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cmp("rst_valid", 32'(aer_valid), 32'd0);
    cmp("rst_addr", 32'(aer_addr), 32'd0);
    cmp("rst_drop", 32'(drop_count), 32'd0);
    spike_in  = '0;
    aer_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] spk;
    rst_n     = 1'b0;
    spike_in  = '0;
    aer_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp("reset_valid", 32'(aer_valid), 32'd0);
    cmp("reset_drop", 32'(drop_count), 32'd0);

    // Single spike: visible two cycles later for one cycle only.
    tick(8'h04, 1'b1);
    cmp("single_c1_valid", 32'(aer_valid), 32'd0);
    tick(8'h00, 1'b1);
    cmp("single_c2_valid", 32'(aer_valid), 32'd1);
    cmp("single_c2_addr", 32'(aer_addr), 32'd2);
    tick(8'h00, 1'b1);
    cmp("single_c3_valid", 32'(aer_valid), 32'd0);

    // Fairness: all neurons at once drain in index order.
    do_reset();
    tick(8'hFF, 1'b1);
    for (int k = 0; k < N; k++) begin
      tick(8'h00, 1'b1);
      cmp("fair_valid", 32'(aer_valid), 32'd1);
      cmp("fair_addr", 32'(aer_addr), 32'(k));
    end
    tick(8'h00, 1'b1);
    cmp("fair_end_valid", 32'(aer_valid), 32'd0);

    // Backpressure holds address 0, then 4 follows.
    do_reset();
    tick(8'h11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(8'h00, 1'b0);
      cmp("bp_hold_addr", 32'(aer_addr), 32'd0);
      cmp("bp_hold_valid", 32'(aer_valid), 32'd1);
    end
    tick(8'h00, 1'b1);
    cmp("bp_next_addr", 32'(aer_addr), 32'd4);
    tick(8'h00, 1'b1);
    cmp("bp_done_valid", 32'(aer_valid), 32'd0);
    cmp("bp_drop", 32'(drop_count), 32'd0);

    // Collision: once neuron 3 sits in the slot, its pulse at 3 re-arms the
    // pending bit and the pulses at 6 and 9 collide with it.
    do_reset();
    for (int c = 0; c < 11; c++) tick((c % 3 == 0) ? 8'h08 : 8'h00, 1'b0);
    cmp("coll_addr", 32'(aer_addr), 32'd3);
    cmp("coll_drop", 32'(drop_count), 32'd2);

    // Flood to saturation, then further collisions must hold at all-ones.
    for (int c = 0; c < 8300; c++) tick(8'hFF, 1'b0);
    cmp("sat_drop", 32'(drop_count), 32'hFFFF);
    for (int c = 0; c < 3; c++) tick(8'h08, 1'b0);
    cmp("sat_hold", 32'(drop_count), 32'hFFFF);

    // Re-spike on the grant edge yields a second event for neuron 5, no drop.
    do_reset();
    tick(8'h20, 1'b1);
    tick(8'h20, 1'b1);
    cmp("respike_addr1", 32'(aer_addr), 32'd5);
    tick(8'h00, 1'b1);
    cmp("respike_valid2", 32'(aer_valid), 32'd1);
    cmp("respike_addr2", 32'(aer_addr), 32'd5);
    cmp("respike_drop", 32'(drop_count), 32'd0);
    tick(8'h00, 1'b1);
    cmp("respike_end", 32'(aer_valid), 32'd0);

    // Reset mid-handshake with three events pending.
    do_reset();
    tick(8'h0F, 1'b0);
    tick(8'h00, 1'b0);
    cmp("midrst_pre_valid", 32'(aer_valid), 32'd1);
    #2;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick(8'h00, 1'b1);
      cmp("midrst_stale", 32'(aer_valid), 32'd0);
    end
`ifdef SPIKE_TIMESTAMP_EN
    // Reset released 4 cycles ago; spike 10 cycles after release loads at counter 11.
    for (int c = 4; c < 10; c++) tick(8'h00, 1'b1);
    tick(8'h02, 1'b1);
    tick(8'h00, 1'b1);
    cmp("ts_value", 32'(aer_tstamp), 32'd11);
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) spk[i] = ($urandom_range(0, 5) == 0);
      tick(spk, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
